// File: rtl/add_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and parameter legality.
package add_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal when the word splits into equal, non-empty chunks.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CW-bit ripple adder built from full-adder cells.
// c_msb is the carry into the top bit, used for signed overflow.
module fadd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb
);
  logic [CW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : bit_g
    fadd u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign co    = c[CW];
  assign c_msb = c[CW-1];
endmodule

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: one CW-bit chunk per stage, carry registered between
// stages, global stall on output back-pressure (bubbles are held, not collapsed).
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : bad_cfg
    $error("add_pipe: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff    = sub ? ~num2 : num2;
  assign c_eff    = sub | cin;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage g holds the low (g+1) result chunks and the still-unused upper operand chunks.
  for (genvar g = 0; g < STAGES; g++) begin : stg
    localparam int RW = (g + 1) * CW;
    localparam int OW = WIDTH - RW;

    logic [CW-1:0] a_c, b_c, s_c;
    logic          ci, co, cm;
    logic          v_in;
    logic [RW-1:0] r_d;
    logic          v_q, c_q;
    logic [RW-1:0] r_q;

    if (g == 0) begin : src
      assign a_c  = num1[CW-1:0];
      assign b_c  = b_eff[CW-1:0];
      assign ci   = c_eff;
      assign v_in = in_valid;
      assign r_d  = s_c;
    end else begin : src
      assign a_c  = stg[g-1].opr.a_q[CW-1:0];
      assign b_c  = stg[g-1].opr.b_q[CW-1:0];
      assign ci   = stg[g-1].c_q;
      assign v_in = stg[g-1].v_q;
      assign r_d  = {s_c, stg[g-1].r_q};
    end

    add_chunk #(.CW(CW)) u_chunk (
      .a(a_c), .b(b_c), .ci(ci), .s(s_c), .co(co), .c_msb(cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= co;
        r_q <= r_d;
      end
    end

    if (OW > 0) begin : opr
      logic [OW-1:0] a_q, b_q, a_d, b_d;

      if (g == 0) begin : fwd
        assign a_d = num1[WIDTH-1:CW];
        assign b_d = b_eff[WIDTH-1:CW];
      end else begin : fwd
        assign a_d = stg[g-1].opr.a_q[OW+CW-1:CW];
        assign b_d = stg[g-1].opr.b_q[OW+CW-1:CW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (g == STAGES - 1) begin : lst
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_q <= 1'b0;
        else if (advance) ovf_q <= co ^ cm;
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign out       = stg[STAGES-1].r_q;
  assign cout      = stg[STAGES-1].c_q;
  assign ovf       = stg[STAGES-1].lst.ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Random + directed bench for add_pipe: 16b/4-stage instance against a queue model,
// plus a 4b/1-stage instance checked against plain arithmetic.
module tb_add_pipe;
  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  num1, num2, out;

  logic          iv4, ir4, sub4, cin4, ov4, or4, co4, of4;
  logic [3:0]    a4, b4, o4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  add_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .cin(cin), .num1(num1), .num2(num2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .cout(cout), .ovf(ovf)
  );

  add_pipe #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .sub(sub4), .cin(cin4), .num1(a4), .num2(b4),
    .out_valid(ov4), .out_ready(or4), .out(o4), .cout(co4), .ovf(of4)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: signed overflow when operands agree in sign and result differs.
  function automatic res_t ref16(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sb, input logic ci);
    res_t         r;
    logic [W-1:0] be;
    logic [W:0]   t;
    be   = sb ? ~b : b;
    t    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Model: occupancy bits per pipeline slot plus in-order queue of expected results.
  logic [S-1:0] mv;
  res_t         q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv = '0;
      q.delete();
    end else if (!mv[S-1] || out_ready) begin
      if (mv[S-1]) void'(q.pop_front());
      if (in_valid) q.push_back(ref16(num1, num2, sub, cin));
      mv = {mv[S-2:0], in_valid};
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, mv[S-1]});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!mv[S-1] || out_ready)});
      if (mv[S-1] && q.size() > 0)
        chk("result", {14'b0, out, cout, ovf}, {14'b0, q[0]});
    end
  end

  task automatic idle();
    in_valid = 0; sub = 0; cin = 0; num1 = '0; num2 = '0;
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sb, input logic ci, input logic [W-1:0] es,
                       input logic eco, input logic eov);
    int n;
    @(posedge clk); #1;
    in_valid = 1; num1 = a; num2 = b; sub = sb; cin = ci; out_ready = 1;
    chk({name, "_rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    idle();
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, n, S - 1);
    chk({name, "_out"}, {14'b0, out, cout, ovf}, {14'b0, es, eco, eov});
  endtask

  task automatic rand_cycle(input int pv, input int pr);
    int sel;
    @(posedge clk); #1;
    in_valid  = ($urandom_range(99) < pv);
    out_ready = ($urandom_range(99) < pr);
    sub = $urandom_range(1); cin = $urandom_range(1);
    sel = $urandom_range(3);
    num1 = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : W'($urandom);
    num2 = (sel == 2) ? 16'hFFFF : W'($urandom);
  endtask

  initial begin
    logic [4:0] t4;
    logic [3:0] be4;
    rst_n = 0; out_ready = 0; idle();
    iv4 = 0; or4 = 1; sub4 = 0; cin4 = 0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", {15'b0, out, cout}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid4", {31'b0, ov4}, 32'd0);

    chk("model_7fff", {14'b0, ref16(16'h7FFF, 16'h0001, 0, 0)}, {14'b0, 16'h8000, 1'b0, 1'b1});
    chk("model_sub", {14'b0, ref16(16'h0005, 16'h0009, 1, 1)}, {14'b0, 16'hFFFC, 1'b0, 1'b0});

    @(posedge clk); #1;
    rst_n = 1; chk_en = 1;

    do_op("add1_2",   16'h0001, 16'h0002, 0, 0, 16'h0003, 0, 0);
    do_op("addffff",  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    do_op("add7fff",  16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    do_op("sub5_9",   16'h0005, 16'h0009, 1, 1, 16'hFFFC, 0, 0);
    do_op("sub8000",  16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1);
    do_op("addcin",   16'h00FF, 16'h0000, 0, 1, 16'h0100, 0, 0);

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1; out_ready = 1; sub = 0; cin = 0;
      num1 = W'(i * 16'h1111); num2 = W'(i);
      chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    end
    @(posedge clk); #1; idle();
    repeat (S + 2) @(posedge clk);

    // Fill the pipe against a stalled consumer, hold, then drain.
    for (int i = 0; i < S + 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1; out_ready = 0; num1 = W'($urandom); num2 = W'($urandom); sub = i[0];
      if (i >= S) chk("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1; idle(); out_ready = 1;
    repeat (S + 2) @(posedge clk);

    for (int i = 0; i < 400; i++) rand_cycle(70, 65);
    @(posedge clk); #1; idle(); out_ready = 1;
    repeat (S + 2) @(posedge clk);

    // Reset with the pipe full: outputs clear without waiting for an edge.
    for (int i = 0; i < S; i++) begin
      @(posedge clk); #1;
      in_valid = 1; out_ready = 0; num1 = W'(16'h1234 + i); num2 = 16'h4321;
    end
    @(posedge clk); #1; idle();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out", {15'b0, out, cout}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1; rst_n = 1; out_ready = 1;
    repeat (S + 4) @(posedge clk);
    for (int i = 0; i < 100; i++) rand_cycle(60, 80);
    @(posedge clk); #1; idle(); out_ready = 1;
    repeat (S + 2) @(posedge clk);

    // Single-stage 4-bit instance: registered adder, one cycle latency.
    @(posedge clk); #1;
    iv4 = 1; a4 = 4'hF; b4 = 4'hF; sub4 = 0; cin4 = 0;
    @(posedge clk); #1;
    iv4 = 0;
    chk("w4_valid", {31'b0, ov4}, 32'd1);
    chk("w4_15p15", {26'b0, o4, co4, of4}, {26'b0, 4'hE, 1'b1, 1'b0});
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      iv4 = 1; a4 = 4'($urandom); b4 = 4'($urandom);
      sub4 = $urandom_range(1); cin4 = $urandom_range(1);
      be4 = sub4 ? ~b4 : b4;
      t4 = {1'b0, a4} + {1'b0, be4} + {4'b0, (sub4 ? 1'b1 : cin4)};
      @(posedge clk); #1;
      iv4 = 0;
      chk("w4_rand", {26'b0, ov4, o4, co4},
          {26'b0, 1'b1, t4[3:0], t4[4]});
      chk("w4_ovf", {31'b0, of4},
          {31'b0, (a4[3] == be4[3]) && (t4[3] != a4[3])});
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
